// File: rtl/free_list_bank_pkg.sv
// Shared constants and types for one rename free-list bank.
// Mirrors the core_types constants the bank depends on and adds the
// per-bank count of indices held by the reset architectural mapping.
package free_list_bank_pkg;

   localparam int PR_COUNT                          = 128;
   localparam int LOG_PR_COUNT                      = 7;
   localparam int PRF_BANK_COUNT                    = 4;
   localparam int LOG_PRF_BANK_COUNT                = 2;
   localparam int AR_COUNT                          = 32;
   localparam int FREE_LIST_BANK_COUNT              = PRF_BANK_COUNT;
   localparam int FREE_LIST_LENGTH_PER_BANK         = 32;
   localparam int LOG_FREE_LIST_LENGTH_PER_BANK     = 5;
   localparam int FREE_LIST_LOWER_THRESHOLD         = 8;
   localparam int FREE_LIST_UPPER_THRESHOLD         = 24;
   localparam int FREE_LIST_INIT_RESERVED_PER_BANK  = AR_COUNT / FREE_LIST_BANK_COUNT;

   // Full physical-register tag, stored index within a bank, and occupancy.
   typedef logic [LOG_PR_COUNT-1:0]                  pr_tag_t;
   typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK-1:0] fl_index_t;
   typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK:0]   fl_count_t;
   typedef logic [LOG_PRF_BANK_COUNT-1:0]            bank_bits_t;

   // Index part of a tag: everything above the bank-select bits.
   function automatic fl_index_t pr_index(input pr_tag_t tag);
      return tag[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
   endfunction

   // Bank-select part of a tag.
   function automatic bank_bits_t pr_bank(input pr_tag_t tag);
      return tag[LOG_PRF_BANK_COUNT-1:0];
   endfunction

endpackage

// File: rtl/free_list_bank_if.sv
// Enqueue/dequeue/status bundle of one free-list bank.
// master: ROB commit + rename side; slave: the bank itself.
interface free_list_bank_if;
   import free_list_bank_pkg::*;

   logic      enq_valid;
   pr_tag_t   enq_PR_tag;
   logic      deq_valid;
   pr_tag_t   deq_PR_tag;
   logic      deq_ready;
   fl_count_t count;
   logic      below_lower;
   logic      above_upper;
   logic      enq_error;

   modport master (
      output enq_valid, enq_PR_tag, deq_ready,
      input  deq_valid, deq_PR_tag, count, below_lower, above_upper, enq_error
   );

   modport slave (
      input  enq_valid, enq_PR_tag, deq_ready,
      output deq_valid, deq_PR_tag, count, below_lower, above_upper, enq_error
   );

endinterface

// File: rtl/free_list_bank.sv
// One bank of the rename free list: circular FIFO of free PR indices whose
// bank bits equal BANK_INDEX (the bank bits are implied, not stored).
// Optional macro FREE_LIST_DOUBLE_FREE_CHECK_EN adds a per-index "already
// free" vector that rejects double frees.
module free_list_bank
   import free_list_bank_pkg::*;
#(
   parameter int BANK_INDEX      = 0,
   parameter int LENGTH          = FREE_LIST_LENGTH_PER_BANK,
   parameter int INIT_RESERVED   = FREE_LIST_INIT_RESERVED_PER_BANK,
   parameter int LOWER_THRESHOLD = FREE_LIST_LOWER_THRESHOLD,
   parameter int UPPER_THRESHOLD = FREE_LIST_UPPER_THRESHOLD
) (
   input logic             CLK,
   input logic             nRST,
   free_list_bank_if.slave fl
);

   localparam bank_bits_t BANK_BITS = bank_bits_t'(BANK_INDEX);

   fl_index_t slot_reg [LENGTH];
   fl_index_t head_reg, head_next;
   fl_index_t tail_reg, tail_next;
   fl_count_t count_reg, count_next;
   logic      enq_error_reg, enq_error_next;

   fl_index_t   enq_index;
   fl_index_t   head_index;
   logic        bank_match;
   logic        full;
   logic        duplicate;
   logic        enq_acc;
   logic        deq_acc;
   logic [LENGTH-1:0] slot_we;

   assign enq_index  = pr_index(fl.enq_PR_tag);
   assign bank_match = (pr_bank(fl.enq_PR_tag) == BANK_BITS);
   assign full       = (count_reg == fl_count_t'(LENGTH));
   assign head_index = slot_reg[head_reg];

   // Status and head entry come straight from registered state (zero-latency read).
   assign fl.deq_valid   = (count_reg != '0);
   assign fl.deq_PR_tag  = {head_index, BANK_BITS};
   assign fl.count       = count_reg;
   assign fl.below_lower = (count_reg <  fl_count_t'(LOWER_THRESHOLD));
   assign fl.above_upper = (count_reg >= fl_count_t'(UPPER_THRESHOLD));
   assign fl.enq_error   = enq_error_reg;

   assign deq_acc = fl.deq_valid && fl.deq_ready;
   assign enq_acc = fl.enq_valid && bank_match && !full && !duplicate;

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
   logic [LENGTH-1:0] in_list_reg, in_list_next;

   // Both set and clear look at pre-cycle state, so an enqueue of the index
   // being dequeued this cycle is still seen as a duplicate.
   assign duplicate = in_list_reg[enq_index];

   generate
      for (genvar gi = 0; gi < LENGTH; gi++) begin : g_in_list
         assign in_list_next[gi] =
            (in_list_reg[gi] && !(deq_acc && head_index == fl_index_t'(gi))) ||
            (enq_acc && enq_index == fl_index_t'(gi));
      end
   endgenerate

   // Free-index membership vector; reset marks every non-reserved index free.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < LENGTH; i++) begin
            in_list_reg[i] <= (i >= INIT_RESERVED);
         end
      end else begin
         in_list_reg <= in_list_next;
      end
   end
`else
   assign duplicate = 1'b0;
`endif

   // One write-enable per slot, selected by the tail pointer.
   generate
      for (genvar gi = 0; gi < LENGTH; gi++) begin : g_slot_we
         assign slot_we[gi] = enq_acc && (tail_reg == fl_index_t'(gi));
      end
   endgenerate

   // Pointer, occupancy and error-pulse next-state; pointers wrap naturally.
   always_comb begin
      head_next      = head_reg;
      tail_next      = tail_reg;
      count_next     = count_reg;
      enq_error_next = 1'b0;
      if (deq_acc) begin
         head_next = head_reg + 1'b1;
      end
      if (enq_acc) begin
         tail_next = tail_reg + 1'b1;
      end
      count_next     = count_reg + fl_count_t'(enq_acc) - fl_count_t'(deq_acc);
      enq_error_next = fl.enq_valid && !enq_acc;
   end

   // Control state registers.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         head_reg      <= '0;
         tail_reg      <= fl_index_t'(LENGTH - INIT_RESERVED);
         count_reg     <= fl_count_t'(LENGTH - INIT_RESERVED);
         enq_error_reg <= 1'b0;
      end else begin
         head_reg      <= head_next;
         tail_reg      <= tail_next;
         count_reg     <= count_next;
         enq_error_reg <= enq_error_next;
      end
   end

   // Index storage; reset loads the non-reserved indices in ascending order.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < LENGTH; i++) begin
            slot_reg[i] <= (i < LENGTH - INIT_RESERVED) ? fl_index_t'(i + INIT_RESERVED) : '0;
         end
      end else begin
         for (int i = 0; i < LENGTH; i++) begin
            if (slot_we[i]) begin
               slot_reg[i] <= enq_index;
            end
         end
      end
   end

endmodule

// File: doc/free_list_bank.md
Name: free_list_bank

Overview:
- Single bank of the rename free list: a circular FIFO of free physical-register (PR) tags whose low bits equal BANK_INDEX.
- Writer side: ROB commit returns freed PRs (enqueue).
- Reader side: rename/dispatch allocates new PRs (dequeue).
- FREE_LIST_BANK_COUNT instances, one per PRF bank; occupancy flags feed rename's bank-steering logic.

Parameters:
- BANK_INDEX, 0, bank number; stored tags carry this value implicitly in PR[LOG_PRF_BANK_COUNT-1:0].
- LENGTH, FREE_LIST_LENGTH_PER_BANK (32), entries per bank; power of two.
- INIT_RESERVED, AR_COUNT/FREE_LIST_BANK_COUNT (8), low indices held by the reset architectural mapping, so not free at reset.
- LOWER_THRESHOLD, FREE_LIST_LOWER_THRESHOLD (8), low-occupancy flag level.
- UPPER_THRESHOLD, FREE_LIST_UPPER_THRESHOLD (24), high-occupancy flag level.

Ports:
- CLK  in  1  clock; single clock domain.
- nRST  in  1  reset; synchronous, active-low.
- enq_valid  in  1  freed-PR return from ROB commit.
- enq_PR_tag  in  LOG_PR_COUNT  freed PR; bank bits must equal BANK_INDEX.
- deq_valid  out  1  head entry available (count != 0).
- deq_PR_tag  out  LOG_PR_COUNT  head PR, {stored index, BANK_INDEX}.
- deq_ready  in  1  rename consumes head this cycle.
- count  out  LOG_FREE_LIST_LENGTH_PER_BANK+1  current occupancy.
- below_lower  out  1  count < LOWER_THRESHOLD.
- above_upper  out  1  count >= UPPER_THRESHOLD.
- enq_error  out  1  registered pulse: rejected enqueue (full, wrong bank, or duplicate with the optional feature).

Behaviour:
- Storage: LENGTH x LOG_FREE_LIST_LENGTH_PER_BANK-bit index array. The bank bits are not stored. Head and tail pointers are LOG_FREE_LIST_LENGTH_PER_BANK bits wide and wrap modulo LENGTH with no special case.
- Reset (rising CLK edge with nRST=0):
  - Array holds indices INIT_RESERVED..LENGTH-1 in slots 0..LENGTH-INIT_RESERVED-1.
  - head=0, tail=LENGTH-INIT_RESERVED (24), count=24.
  - Outputs after reset: deq_valid=1, deq_PR_tag={8,BANK_INDEX}, below_lower=0, above_upper=1, enq_error=0.
  - Reset mid-operation discards all in-flight state; a same-cycle enq/deq is ignored.
- Dequeue:
  - deq_valid, deq_PR_tag and the flags are combinational from registered head/count. Zero-latency read.
  - A dequeue occurs when deq_valid && deq_ready; head advances next cycle.
  - deq_ready with count==0 is a no-op.
- Enqueue:
  - Accepted iff enq_valid, the bank bits match, count<LENGTH, and (with the feature) the tag is not already free.
  - Writes array[tail], then tail advances.
  - Otherwise the tag is dropped and enq_error=1 the next cycle only. Pointers and count are unchanged.
- Simultaneous accepted enq and deq: both pointers advance and count is unchanged.
  - Legal at count==0 and count==LENGTH: enqueue checks fullness on pre-cycle count, so at full with a simultaneous deq the enqueue is still rejected.
  - An enqueued tag is not visible at deq_PR_tag until the following cycle; no bypass.
- count arithmetic: next = count + enq_acc - deq_acc. Saturation cannot occur because of the guards.

Optional Feature:
- FREE_LIST_DOUBLE_FREE_CHECK_EN:
  - Defined: adds a LENGTH-bit in_list vector indexed by stored index.
    - Reset value: 1 for indices >= INIT_RESERVED.
    - Set on accepted enqueue, cleared on dequeue.
    - An enqueue of an index whose bit is already set is rejected with enq_error.
    - If a dequeue and an enqueue of the same index coincide, the clear (dequeue) and the set (enqueue) are evaluated against pre-cycle state, so the enqueue is rejected.
  - Undefined: no vector; duplicates are accepted silently.

Decomposition:
- core_types_pkg supplies PR_COUNT, LOG_PR_COUNT, FREE_LIST_* constants and AR_COUNT.
- Add to the package: FREE_LIST_INIT_RESERVED_PER_BANK = AR_COUNT/FREE_LIST_BANK_COUNT.
- One flat module, no sub-module. The wrapper instantiating FREE_LIST_BANK_COUNT banks is a separate block.

Test Plan:
- Reset, BANK_INDEX=2 -> deq_PR_tag=0x22 ({8,2}), count=24, above_upper=1, below_lower=0.
- 17 consecutive dequeues -> tags 0x22,0x26,...,0x62; count=7; below_lower=1, asserted the cycle after the 17th dequeue.
- Drain 24 -> deq_valid=0. Enq 0x7E -> next cycle deq_valid=1, deq_PR_tag=0x7E.
- Fill to 32 via 8 enqueues, then enq 0x02 with deq_ready=1 -> deq taken, enq rejected, enq_error pulses, count=31.
- Enq 0x01 (bank 1 into bank 2) -> enq_error=1, count unchanged.
- With FREE_LIST_DOUBLE_FREE_CHECK_EN: re-enq a free tag 0x26 -> enq_error=1, count unchanged. Without the macro: accepted, count+1.
